muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit for the EX stage of the pipelined MIPS core. Adds MULT/MULTU/DIV/DIVU with HI/LO registers to a datapath whose ALU is single-cycle only.
- Issues stall requests to the hazard logic while a long operation is in flight.
- Sits beside the EX-stage ALU and takes forwarded operands.
- Result registers are read by MFHI/MFLO in EX.

Parameters:
- WIDTH, 32, operand and HI/LO width (≥4, even).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request operation `op` this cycle.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others = no-op.
- a  in  WIDTH  operand A (rs, forwarded).
- b  in  WIDTH  operand B (rt, forwarded).
- mf_req  in  1  EX holds MFHI/MFLO this cycle.
- flush  in  1  abort in-flight operation (branch/exception squash).
- busy  out  1  operation in flight.
- stall_req  out  1  = busy & (start | mf_req); combinational.
- done  out  1  one-cycle pulse, HI/LO just updated by mul/div.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset: state IDLE; hi=0, lo=0, busy=0, done=0; counter=0. Reset overrides all inputs, including mid-operation.
- States: IDLE, MUL, DIV, FIXUP.
- IDLE, start with op=MTHI/MTLO: hi<=a or lo<=a at that edge. No busy, no done.
- IDLE, start with op=MULT*/DIV*: latch |a|, |b| (magnitudes for signed ops, raw for unsigned), result signs, counter<=WIDTH. Next state MUL or DIV.
- MUL: one shift-add step per cycle on a 2*WIDTH accumulator. Counter decrements; at 1, go to FIXUP.
- DIV: one restoring shift-subtract step per cycle. Same counter rule.
- FIXUP: apply signs. Signed product is negated if sign(a)^sign(b). Signed quotient truncates toward zero and is negated if signs differ; remainder takes the sign of the dividend.
- FIXUP writes hi/lo at its closing edge; done=1 for the following cycle; then IDLE.
- MUL: hi=upper, lo=lower product. DIV: lo=quotient, hi=remainder.
- Latency: start sampled at edge E0; busy high for cycles E0+1 … E0+WIDTH+1 (WIDTH iterations + FIXUP); new hi/lo and done visible in cycle E0+WIDTH+2. For WIDTH=32, results arrive 34 cycles after the issue edge.
- start while busy: ignored by the unit; stall_req=1 so the pipeline holds the instruction.
- Back-to-back: start is accepted in the done cycle (state is IDLE).
- Divide by zero (b=0, DIV or DIVU): no trap. lo=all ones, hi=a (original signed value).
- Signed overflow (DIV of most-negative by -1): lo=most-negative, hi=0.
- Magnitude of most-negative value: treated as unsigned 2^(WIDTH-1), no overflow.
- flush while busy: return to IDLE next edge; hi/lo unchanged; no done.
- flush and start in the same IDLE cycle: flush wins, nothing is latched.
- mf_req in IDLE: no stall. hi/lo are always register outputs with no combinational path from a/b.

Decomposition:
- Shared package mips_pkg: op encodings (OP_MULT … OP_MTLO), state enum, WIDTH default.
- One sub-module, muldiv_signfix: combinational abs/negate/sign-select used at operand latch and in FIXUP.

Test Plan (WIDTH=32):
- MULT a=0xFFFFFFFD (-3), b=7 → after 34 cycles hi=0xFFFFFFFF, lo=0xFFFFFFEB; done pulse exactly once; busy high 33 cycles.
- DIVU a=100, b=7 → lo=0x0000000E, hi=0x00000002. Then DIV a=-7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=5, b=0 → lo=0xFFFFFFFF, hi=0x00000005. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF in flight; assert start (MTHI) and mf_req at cycle 5 → stall_req=1 each such cycle; MTHI ignored; final hi=0xFFFFFFFE, lo=0x00000001.
- MTLO 0x1234 then MULT 2×3; flush at cycle 10 → busy drops next cycle, lo stays 0x1234, no done.
- rst asserted mid-DIV → next cycle hi=lo=0, busy=0. New MULT 4×5 right after reset → lo=20, hi=0.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared op encodings, FSM states and defaults for the mul/div unit
package mips_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIXUP
  } md_state_t;

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// rtl/muldiv_signfix.sv - conditional two's-complement negate used for operand magnitudes and result sign fixup
module muldiv_signfix #(
  parameter int N = 32
) (
  input  logic [N-1:0] val,
  input  logic         neg,
  output logic [N-1:0] res
);

  // The most-negative value maps onto itself, which read as unsigned is 2^(N-1).
  assign res = neg ? (~val + N'(1)) : val;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers for the EX stage
module muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mf_req,
  input  logic             flush,
  output logic             busy,
  output logic             stall_req,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int W2 = 2 * WIDTH;

  md_state_t        state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [W2-1:0]    acc;
  logic [WIDTH-1:0] mc;
  logic [WIDTH-1:0] a_orig;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             neg_res, neg_rem, div_zero, is_div, done_q;

  logic             op_signed;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  logic             launch_mul, launch_div, write_hi, write_lo, last_iter;

  logic [WIDTH:0]   mul_upper;
  logic [W2-1:0]    mul_next;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic [W2-1:0]    div_next;

  assign op_signed = op_is_signed(op);
  assign last_iter = (cnt == CNT_W'(1));

  muldiv_signfix #(.N(WIDTH)) u_abs_a (.val(a), .neg(op_signed & a[WIDTH-1]), .res(abs_a));
  muldiv_signfix #(.N(WIDTH)) u_abs_b (.val(b), .neg(op_signed & b[WIDTH-1]), .res(abs_b));
  muldiv_signfix #(.N(W2))    u_fix_prod (.val(acc), .neg(neg_res), .res(prod_fix));
  muldiv_signfix #(.N(WIDTH)) u_fix_quo (.val(acc[WIDTH-1:0]), .neg(neg_res), .res(quo_fix));
  muldiv_signfix #(.N(WIDTH)) u_fix_rem (.val(acc[W2-1:WIDTH]), .neg(neg_rem), .res(rem_fix));

  // Multiply: acc holds {partial product, remaining multiplier bits}.
  assign mul_upper = {1'b0, acc[W2-1:WIDTH]} + (acc[0] ? {1'b0, mc} : {(WIDTH + 1){1'b0}});
  assign mul_next  = {mul_upper, acc[WIDTH-1:1]};

  // Divide: acc holds {partial remainder, quotient/dividend}; the remainder
  // after a successful subtract is below the divisor, so WIDTH bits suffice.
  assign div_shift = {acc[W2-1:WIDTH], acc[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, mc});
  assign div_diff  = div_shift[WIDTH-1:0] - mc;
  assign div_next  = div_ge ? {div_diff, acc[WIDTH-2:0], 1'b1}
                            : {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    launch_mul = 1'b0;
    launch_div = 1'b0;
    write_hi   = 1'b0;
    write_lo   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start && !flush) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              launch_mul = 1'b1;
              state_next = ST_MUL;
            end
            OP_DIV, OP_DIVU: begin
              launch_div = 1'b1;
              state_next = ST_DIV;
            end
            OP_MTHI: write_hi = 1'b1;
            OP_MTLO: write_lo = 1'b1;
            default: ;
          endcase
        end
      end
      ST_MUL, ST_DIV: begin
        if (flush) begin
          state_next = ST_IDLE;
        end else if (last_iter) begin
          state_next = ST_FIXUP;
        end
      end
      ST_FIXUP: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      acc      <= '0;
      mc       <= '0;
      a_orig   <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      is_div   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (write_hi) hi_q <= a;
      if (write_lo) lo_q <= a;
      if (launch_mul || launch_div) begin
        cnt      <= CNT_W'(WIDTH);
        is_div   <= launch_div;
        acc      <= {{WIDTH{1'b0}}, (launch_mul ? abs_b : abs_a)};
        mc       <= launch_mul ? abs_a : abs_b;
        a_orig   <= a;
        neg_res  <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_rem  <= op_signed & a[WIDTH-1];
        div_zero <= (b == '0);
      end
      if (state == ST_MUL) begin
        acc <= mul_next;
        cnt <= cnt - CNT_W'(1);
      end
      if (state == ST_DIV) begin
        acc <= div_next;
        cnt <= cnt - CNT_W'(1);
      end
      if ((state == ST_FIXUP) && !flush) begin
        done_q <= 1'b1;
        if (!is_div) begin
          hi_q <= prod_fix[W2-1:WIDTH];
          lo_q <= prod_fix[WIDTH-1:0];
        end else if (div_zero) begin
          hi_q <= a_orig;
          lo_q <= '1;
        end else begin
          hi_q <= rem_fix;
          lo_q <= quo_fix;
        end
      end
    end
  end

  assign busy      = (state != ST_IDLE);
  assign stall_req = busy & (start | mf_req);
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule
